// File: rtl/ame_pivot_swap.sv
// ame_pivot_swap: partial-pivoting stage of the affine-ME Gaussian-elimination solver.
// Holds the 6-row augmented matrix. For step k it sends |col k| of rows k..5 to an external
// max comparator, then swaps row k with the returned pivot row.
// Optional feature macro: AME_PIVOT_TIMEOUT_EN (bounded comparator wait with timeout pulse).

// Saturating absolute value: the most negative input maps to the most positive value,
// so every comparator operand is non-negative.
module ame_pivot_sat_abs #(
    parameter int DATA_BITS = 64
) (
    input  logic [DATA_BITS-1:0] din_i,
    output logic [DATA_BITS-1:0] dout_o
);
    localparam logic [DATA_BITS-1:0] MIN_VAL = {1'b1, {(DATA_BITS-1){1'b0}}};

    // Negate negatives, clamp the one value whose negation overflows
    always_comb begin
        dout_o = din_i;
        if (din_i == MIN_VAL) begin
            dout_o = ~MIN_VAL;
        end else if (din_i[DATA_BITS-1]) begin
            dout_o = '0 - din_i;
        end
    end
endmodule

module ame_pivot_swap #(
    parameter int DATA_BITS      = 64,
    parameter int IDX_BITS       = 3,
    parameter int NUM_COLS       = 7,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          load_valid_i,
    input  logic [IDX_BITS-1:0]           load_row_i,
    input  logic [NUM_COLS*DATA_BITS-1:0] load_data_i,
    input  logic                          rd_en_i,
    input  logic [IDX_BITS-1:0]           rd_row_i,
    output logic [NUM_COLS*DATA_BITS-1:0] rd_data_o,
    output logic                          rd_valid_o,
    input  logic                          start_i,
    input  logic [IDX_BITS-1:0]           step_k_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [IDX_BITS-1:0]           pivot_idx_o,
    output logic                          singular_o,
    output logic                          timeout_o,
    output logic                          comp_init_o,
    output logic [6*DATA_BITS-1:0]        comp_data_o,
    input  logic                          comp_done_i,
    input  logic [DATA_BITS-1:0]          comp_data_i,
    input  logic [IDX_BITS-1:0]           comp_data_idx_i
);
    localparam int NUM_ROWS = 6;
    localparam logic [IDX_BITS-1:0] LAST_ROW = IDX_BITS'(NUM_ROWS - 1);

    typedef logic [NUM_COLS-1:0][DATA_BITS-1:0] row_t;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    state_e                              state_q, state_d;
    logic [IDX_BITS-1:0]                 k_q, k_d;
    row_t [NUM_ROWS-1:0]                 mat_q, mat_d, mat_ld;
    row_t                                rd_data_q, rd_data_d;
    logic                                rd_valid_q, rd_valid_d;
    logic                                done_q, done_d;
    logic [IDX_BITS-1:0]                 pivot_q, pivot_d;
    logic                                sing_q, sing_d;
    logic                                init_q, init_d;
    logic [NUM_ROWS-1:0][DATA_BITS-1:0]  comp_q, comp_d;
    logic [NUM_ROWS-1:0][DATA_BITS-1:0]  abs_w;
    logic [IDX_BITS-1:0]                 k_col;
    logic                                sing_w;

`ifdef AME_PIVOT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    // Loads commit before the pivot search so a same-cycle start sees the new row
    always_comb begin
        mat_ld = mat_q;
        if (state_q == S_IDLE && load_valid_i && load_row_i <= LAST_ROW) begin
            mat_ld[load_row_i] = load_data_i;
        end
    end

    // Column selector for the operand builders; out-of-range k never reaches REQ
    always_comb begin
        k_col = '0;
        if (step_k_i <= LAST_ROW) begin
            k_col = step_k_i;
        end
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        ame_pivot_sat_abs #(.DATA_BITS(DATA_BITS)) u_abs (
            .din_i  (mat_ld[r][k_col]),
            .dout_o (abs_w[r])
        );
    end

    // A pivot is unusable if the max is zero or the index lies outside rows k..5
    always_comb begin
        sing_w = (comp_data_i == '0) || (comp_data_idx_i < k_q) || (comp_data_idx_i > LAST_ROW);
    end

    // Next-state logic for FSM, matrix, read port and registered outputs
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        mat_d      = mat_ld;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en_i;
        done_d     = 1'b0;
        pivot_d    = pivot_q;
        sing_d     = sing_q;
        init_d     = 1'b0;
        comp_d     = comp_q;
`ifdef AME_PIVOT_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif

        // Reads see the matrix as it stood before this edge's write or swap
        if (rd_en_i) begin
            rd_data_d = '0;
            if (rd_row_i <= LAST_ROW) begin
                rd_data_d = mat_q[rd_row_i];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_i && step_k_i <= LAST_ROW) begin
                    state_d = S_REQ;
                    k_d     = step_k_i;
                    init_d  = 1'b1;
                    for (int r = 0; r < NUM_ROWS; r++) begin
                        comp_d[r] = (IDX_BITS'(r) < step_k_i) ? '0 : abs_w[r];
                    end
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
`ifdef AME_PIVOT_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (comp_done_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    sing_d  = sing_w;
                    pivot_d = sing_w ? k_q : comp_data_idx_i;
                    if (!sing_w && comp_data_idx_i != k_q) begin
                        mat_d[k_q]             = mat_q[comp_data_idx_i];
                        mat_d[comp_data_idx_i] = mat_q[k_q];
                    end
`ifdef AME_PIVOT_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    sing_d    = 1'b1;
                    pivot_d   = k_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any step in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            mat_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            pivot_q    <= '0;
            sing_q     <= 1'b0;
            init_q     <= 1'b0;
            comp_q     <= '0;
`ifdef AME_PIVOT_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            mat_q      <= mat_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            pivot_q    <= pivot_d;
            sing_q     <= sing_d;
            init_q     <= init_d;
            comp_q     <= comp_d;
`ifdef AME_PIVOT_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign pivot_idx_o = pivot_q;
    assign singular_o  = sing_q;
    assign comp_init_o = init_q;
    assign comp_data_o = comp_q;
`ifdef AME_PIVOT_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`else
    assign timeout_o   = 1'b0;
`endif
endmodule

// File: tb/tb_ame_pivot_swap.sv
// Directed bench for ame_pivot_swap with a 1-cycle comparator model (ties -> higher index).
module tb_ame_pivot_swap;
    localparam int DB = 64, IB = 3, NC = 7, NR = 6;
    localparam logic [DB-1:0] MINV = 64'h8000_0000_0000_0000;
    localparam logic [DB-1:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
    typedef logic [NC*DB-1:0] row_v;

    logic              clk_i = 1'b0, rst_n_i = 1'b0;
    logic              load_valid_i = 1'b0, rd_en_i = 1'b0, start_i = 1'b0, comp_done_i = 1'b0;
    logic [IB-1:0]     load_row_i = '0, rd_row_i = '0, step_k_i = '0, comp_data_idx_i = '0;
    logic [NC*DB-1:0]  load_data_i = '0;
    logic [DB-1:0]     comp_data_i = '0;
    logic [NC*DB-1:0]  rd_data_o;
    logic              rd_valid_o, busy_o, done_o, singular_o, timeout_o, comp_init_o;
    logic [IB-1:0]     pivot_idx_o;
    logic [6*DB-1:0]   comp_data_o;

    ame_pivot_swap dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .load_valid_i(load_valid_i), .load_row_i(load_row_i), .load_data_i(load_data_i),
        .rd_en_i(rd_en_i), .rd_row_i(rd_row_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .start_i(start_i), .step_k_i(step_k_i), .busy_o(busy_o), .done_o(done_o),
        .pivot_idx_o(pivot_idx_o), .singular_o(singular_o), .timeout_o(timeout_o),
        .comp_init_o(comp_init_o), .comp_data_o(comp_data_o), .comp_done_i(comp_done_i),
        .comp_data_i(comp_data_i), .comp_data_idx_i(comp_data_idx_i)
    );

    always #5 clk_i = ~clk_i;

    logic [DB-1:0] m [NR][NC];
    logic [IB:0]   sb_q[$];
    row_v          rd_q[$];
    int            n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [NC*DB-1:0] got, input logic [NC*DB-1:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic row_v pack_row(input int r);
        row_v v = '0;
        if (r < NR) for (int c = 0; c < NC; c++) v[c*DB +: DB] = m[r][c];
        return v;
    endfunction

    function automatic logic [DB-1:0] sabs(input logic [DB-1:0] x);
        if (x == MINV) return MAXV;
        if ($signed(x) < 0) return -x;
        return x;
    endfunction

    task automatic load_row(input int r);
        load_valid_i = 1'b1; load_row_i = IB'(r); load_data_i = pack_row(r);
        tick();
        load_valid_i = 1'b0;
    endtask

    task automatic read_check(input int r, input string tag);
        row_v e;
        rd_en_i = 1'b1; rd_row_i = IB'(r);
        rd_q.push_back(pack_row(r));
        tick();
        rd_en_i = 1'b0;
        chk({tag, "_rdvalid"}, rd_valid_o, 1'b1);
        e = rd_q.pop_front();
        chk({tag, "_rddata"}, rd_data_o, e);
    endtask

    task automatic read_all(input string tag);
        for (int r = 0; r < NR; r++) read_check(r, $sformatf("%s_r%0d", tag, r));
    endtask

    // One pivot step; any load the caller set up rides along with start
    task automatic do_step(input int k, input int delay, input string tag);
        logic [6*DB-1:0] ops;
        logic [DB-1:0]   best, cv, op;
        int              bi, ci, piv;
        logic            sing;
        logic [IB:0]     e;
        ops = '0; best = '0; bi = k;
        for (int r = 0; r < NR; r++) begin
            op = (r < k) ? '0 : sabs(m[r][k]);
            ops[r*DB +: DB] = op;
            if (r >= k && op >= best) begin best = op; bi = r; end
        end
        sing = (best == '0);
        piv  = sing ? k : bi;
        sb_q.push_back({sing, IB'(piv)});
        start_i = 1'b1; step_k_i = IB'(k);
        tick();
        start_i = 1'b0; load_valid_i = 1'b0;
        chk({tag, "_init"}, comp_init_o, 1'b1);
        chk({tag, "_busy"}, busy_o, 1'b1);
        chk({tag, "_ops"}, comp_data_o, ops);
        cv = '0; ci = 0;
        for (int r = 0; r < NR; r++)
            if (comp_data_o[r*DB +: DB] >= cv) begin cv = comp_data_o[r*DB +: DB]; ci = r; end
        tick();
        repeat (delay) tick();
        comp_done_i = 1'b1; comp_data_i = cv; comp_data_idx_i = IB'(ci);
        tick();
        comp_done_i = 1'b0;
        chk({tag, "_done"}, done_o, 1'b1);
        e = sb_q.pop_front();
        chk({tag, "_pivot"}, pivot_idx_o, e[IB-1:0]);
        chk({tag, "_sing"}, singular_o, e[IB]);
        chk({tag, "_tmo"}, timeout_o, 1'b0);
        if (!e[IB] && int'(e[IB-1:0]) != k) begin
            for (int c = 0; c < NC; c++) begin
                op = m[k][c]; m[k][c] = m[e[IB-1:0]][c]; m[e[IB-1:0]][c] = op;
            end
        end
        tick();
        chk({tag, "_pulse"}, done_o, 1'b0);
        chk({tag, "_idle"}, busy_o, 1'b0);
    endtask

    initial begin
        logic [DB-1:0] c0 [NR], c1 [NR], c2 [NR];
        c0 = '{64'd3, -64'sd9, 64'd5, 64'd0, 64'd2, -64'sd1};
        c1 = '{64'd7, 64'd50, -64'sd3, 64'd10, 64'd20, -64'sd49};
        c2 = '{64'd100, 64'd100, 64'd4, -64'sd7, 64'd0, 64'd1};

        // reset state
        #12;
        chk("rst_rddata", rd_data_o, '0);
        chk("rst_rdvalid", rd_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_pivot", pivot_idx_o, '0);
        chk("rst_sing", singular_o, 1'b0);
        chk("rst_tmo", timeout_o, 1'b0);
        chk("rst_init", comp_init_o, 1'b0);
        chk("rst_ops", comp_data_o, '0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();

        // load the matrix
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) m[r][c] = 64'((r + 1) * 1000 + c);
            m[r][0] = c0[r]; m[r][1] = c1[r]; m[r][2] = c2[r];
            m[r][4] = (r >= 4) ? '0 : 64'(r + 11);
            load_row(r);
        end
        read_all("init");
        read_check(7, "row7");

        do_step(0, 0, "k0");
        read_all("k0");
        do_step(2, 2, "k2slow");
        read_all("k2");
        do_step(1, 0, "k1");
        read_all("k1");
        do_step(4, 0, "k4sing");
        read_all("k4");

        // stray comparator result in IDLE
        comp_done_i = 1'b1; comp_data_i = 64'd5; comp_data_idx_i = 3'd2;
        tick();
        comp_done_i = 1'b0;
        chk("stray_done", done_o, 1'b0);
        chk("stray_busy", busy_o, 1'b0);

        // out-of-range step is ignored
        start_i = 1'b1; step_k_i = 3'd6;
        tick();
        start_i = 1'b0;
        chk("k6_busy", busy_o, 1'b0);
        chk("k6_init", comp_init_o, 1'b0);
        tick();
        chk("k6_done", done_o, 1'b0);

        // saturating operand with same-cycle load+start
        m[5][5] = MINV;
        load_valid_i = 1'b1; load_row_i = 3'd5; load_data_i = pack_row(5);
        do_step(5, 0, "k5sat");
        read_check(5, "k5");

        // reset during WAIT, then a late comparator result
        start_i = 1'b1; step_k_i = 3'd0;
        tick();
        start_i = 1'b0;
        tick();
        chk("mid_busy_pre", busy_o, 1'b1);
        rst_n_i = 1'b0;
        #1;
        chk("mid_busy", busy_o, 1'b0);
        chk("mid_ops", comp_data_o, '0);
        chk("mid_rd", rd_data_o, '0);
        chk("mid_pivot", pivot_idx_o, '0);
        #2;
        rst_n_i = 1'b1;
        for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) m[r][c] = '0;
        comp_done_i = 1'b1; comp_data_i = 64'd9; comp_data_idx_i = 3'd1;
        tick();
        comp_done_i = 1'b0;
        chk("late_done", done_o, 1'b0);
        chk("late_busy", busy_o, 1'b0);
        read_all("postrst");

`ifdef AME_PIVOT_TIMEOUT_EN
        begin
            int cyc;
            cyc = 0;
            start_i = 1'b1; step_k_i = 3'd0;
            tick();
            start_i = 1'b0;
            while (!done_o && cyc < 40) begin tick(); cyc++; end
            chk("tmo_done", done_o, 1'b1);
            chk("tmo_cycles", 32'(cyc), 32'd16);
            chk("tmo_pulse", timeout_o, 1'b1);
            chk("tmo_sing", singular_o, 1'b1);
            chk("tmo_pivot", pivot_idx_o, '0);
            tick();
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
